token_lexer: RTL and testbench
==============================

Name: token_lexer

Overview:
- Turns a serial ASCII character stream (e.g. one line of IN.txt) into the operand/operator token stream consumed by converter.
- Drives converter's input side (input_stb / input_data / is_input_operator / input_ack) as the transmitter of that protocol.
- Decimal digit runs become one operand token; operator characters become operator tokens.
- A line terminator emits an end token.

Parameters:
- WIDTH, 32, operand width; equals converter input_data width.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-low.
- char_stb  input  1  source has a valid character.
- char_data  input  8  ASCII character.
- char_ack  output  1  lexer accepts char_data this cycle.
- output_stb  output  1  token valid.
- output_data  output  WIDTH  operand value, or operator ASCII code zero-extended.
- is_output_operator  output  1  1 = operator/end token, 0 = operand.
- output_ack  input  1  downstream (converter input_ack) accepts token.
- overflow  output  1  sticky: an operand exceeded 2^WIDTH-1.
- bad_char  output  1  sticky: an unrecognised character was received.

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-low.
  - While RST=0: state=IDLE, accumulator=0, pending-op=0, output_stb=0, output_data=0, is_output_operator=0, overflow=0, bad_char=0.
  - char_ack=0 during reset.
  - Reset mid-operation discards any partial number and any pending token; no token is emitted afterwards for it.
- Handshakes:
  - A character transfers on a cycle with char_stb & char_ack.
  - A token transfers on a cycle with output_stb & output_ack.
  - Once output_stb=1, output_data and is_output_operator hold stable until transfer.
  - char_ack is combinational: 1 only in IDLE or NUM.
- Character classes:
  - Digit: '0'-'9'.
  - Operator: '+' '-' '*' '/' '(' ')'.
  - Terminator: '=' or 0x0A; emitted as operator token 0x3D.
  - Space: 0x20, skipped.
  - Anything else: sets bad_char and is otherwise treated as a space.
- States:
  - IDLE, digit: acc<=digit, go NUM.
  - IDLE, space or bad char: stay IDLE.
  - IDLE, operator or terminator: latch code, go EMIT_OP.
  - NUM, digit: acc<=acc*10+digit, stay NUM.
  - NUM, space or bad char: go EMIT_NUM, pending-op=none.
  - NUM, operator or terminator: latch code as pending-op, go EMIT_NUM.
  - EMIT_NUM: output_stb=1, data=acc, is_op=0. On transfer: go EMIT_OP if pending-op, else IDLE.
  - EMIT_OP: output_stb=1, data=code, is_op=1. On transfer: go IDLE, clear acc.
- Latency:
  - The delimiter character is accepted in cycle n; the token is asserted in cycle n+1.
  - Back-to-back tokens with output_ack held 1: number at n+1, operator at n+2, char_ack=1 again at n+3.
- Arithmetic:
  - acc*10 is computed as (acc<<3)+(acc<<1) plus digit in WIDTH+4 bits.
  - Nonzero upper 4 bits set overflow; acc keeps the low WIDTH bits (wrap modulo 2^WIDTH).
- Boundary conditions:
  - Leading zeros are permitted ("007" -> 7).
  - No unary minus: '-' is always an operator.
  - Consecutive operators emit separate tokens.
  - Terminator with no preceding digits emits only the end token.
  - output_ack held 0 indefinitely: lexer stalls with char_ack=0; no character is lost.
  - output_ack asserted while output_stb=0 is ignored.
- Sticky flags clear only on reset.

Decomposition:
- Shared package lexer_pkg holds:
  - ASCII constants (digit range, operator codes, 0x20, 0x0A, 0x3D end code);
  - state encoding IDLE/NUM/EMIT_NUM/EMIT_OP;
  - the is_operator token-flag convention shared with converter and calculator.
- One sub-module, dec_accum, owns the multiply-by-10-plus-digit datapath and overflow detect. The FSM stays in token_lexer.

Test Plan:
- "12+3=" with output_ack=1 -> tokens (12,0), (0x2B,1), (3,0), (0x3D,1), in that order; overflow=0, bad_char=0.
- "( 4 *5)\n" -> (0x28,1), (4,0), (0x2A,1), (5,0), (0x29,1), (0x3D,1); spaces produce no tokens.
- "4294967296=" with WIDTH=32 -> (0,0), (0x3D,1); overflow=1 and stays 1 until RST=0.
- "7+8=" with output_ack held 0 for 20 cycles after the first output_stb -> output_data=7 held stable, char_ack=0 throughout; full correct token sequence once ack resumes.
- "9#1=" -> bad_char=1; tokens (9,0), (1,0), (0x3D,1).
- RST pulsed low while in NUM after "56" -> all outputs 0 immediately (async); subsequent "2=" yields (2,0), (0x3D,1) with no 56 token.

Source files
------------

// File: rtl/lexer_pkg.sv
// Shared lexer definitions: ASCII codes, character classes, FSM states and the
// is_operator token-flag convention used by token_lexer, converter and calculator.
package lexer_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned OVF_W   = 4;

  localparam logic [CHAR_W-1:0] CH_ZERO   = 8'h30;
  localparam logic [CHAR_W-1:0] CH_NINE   = 8'h39;
  localparam logic [CHAR_W-1:0] CH_LPAREN = 8'h28;
  localparam logic [CHAR_W-1:0] CH_RPAREN = 8'h29;
  localparam logic [CHAR_W-1:0] CH_STAR   = 8'h2A;
  localparam logic [CHAR_W-1:0] CH_PLUS   = 8'h2B;
  localparam logic [CHAR_W-1:0] CH_MINUS  = 8'h2D;
  localparam logic [CHAR_W-1:0] CH_SLASH  = 8'h2F;
  localparam logic [CHAR_W-1:0] CH_SPACE  = 8'h20;
  localparam logic [CHAR_W-1:0] CH_LF     = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_EQ     = 8'h3D;
  localparam logic [CHAR_W-1:0] END_CODE  = CH_EQ;

  // is_operator flag: operands carry 0, operator and end tokens carry 1
  localparam logic TOK_OPERAND  = 1'b0;
  localparam logic TOK_OPERATOR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_NUM      = 2'd1,
    S_EMIT_NUM = 2'd2,
    S_EMIT_OP  = 2'd3
  } lex_state_e;

  typedef enum logic [2:0] {
    CC_DIGIT = 3'd0,
    CC_OP    = 3'd1,
    CC_TERM  = 3'd2,
    CC_SPACE = 3'd3,
    CC_BAD   = 3'd4
  } char_class_e;

  // Operator deferred behind the number it terminated
  typedef struct packed {
    logic              vld;
    logic [CHAR_W-1:0] code;
  } pend_op_t;

  function automatic char_class_e classify(input logic [CHAR_W-1:0] c);
    char_class_e cls;
    if (c >= CH_ZERO && c <= CH_NINE) begin
      cls = CC_DIGIT;
    end else if (c == CH_PLUS || c == CH_MINUS || c == CH_STAR ||
                 c == CH_SLASH || c == CH_LPAREN || c == CH_RPAREN) begin
      cls = CC_OP;
    end else if (c == CH_EQ || c == CH_LF) begin
      cls = CC_TERM;
    end else if (c == CH_SPACE) begin
      cls = CC_SPACE;
    end else begin
      cls = CC_BAD;
    end
    return cls;
  endfunction

  // Terminators are all reported downstream as the single end code
  function automatic logic [CHAR_W-1:0] token_code(input logic [CHAR_W-1:0] c);
    return (classify(c) == CC_TERM) ? END_CODE : c;
  endfunction

endpackage

// File: rtl/token_lexer_dec_accum.sv
// Decimal accumulator: acc*10+digit computed as shifts in WIDTH+4 bits,
// wrapping to WIDTH bits with a sticky overflow flag when the top bits are used.
module dec_accum
  import lexer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_mac,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [WIDTH-1:0]   o_acc,
  output logic               o_overflow
);

  localparam int unsigned WIDE_W = WIDTH + OVF_W;

  logic [WIDTH-1:0]  r_acc;
  logic              r_ovf;
  logic [WIDE_W-1:0] w_acc_ext;
  logic [WIDE_W-1:0] w_wide;
  logic              w_carry;

  assign w_acc_ext = WIDE_W'(r_acc);
  assign w_wide    = (w_acc_ext << 3) + (w_acc_ext << 1) + WIDE_W'(i_digit);
  assign w_carry   = (w_wide[WIDE_W-1:WIDTH] != OVF_W'(0));

  // Clear has priority; load starts a new number; mac extends the current one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_load) begin
        r_acc <= WIDTH'(i_digit);
      end else if (i_mac) begin
        r_acc <= w_wide[WIDTH-1:0];
        if (w_carry) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign o_acc      = r_acc;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/token_lexer.sv
// Character-to-token lexer: digit runs become operand tokens, operator and
// terminator characters become operator tokens, driven over a stb/ack handshake.
module token_lexer
  import lexer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              char_stb,
  input  logic [7:0]        char_data,
  output logic              char_ack,
  output logic              output_stb,
  output logic [WIDTH-1:0]  output_data,
  output logic              is_output_operator,
  input  logic              output_ack,
  output logic              overflow,
  output logic              bad_char
);

  lex_state_e        r_state;
  lex_state_e        w_state_nxt;
  char_class_e       w_cls;
  logic [CHAR_W-1:0] w_code;
  logic              w_char_xfer;
  logic              w_tok_xfer;

  pend_op_t          r_pend;
  logic              r_out_stb;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_op;
  logic              r_bad;

  logic              w_acc_clear;
  logic              w_acc_load;
  logic              w_acc_mac;
  logic              w_num_load;
  logic              w_op_load;
  logic [CHAR_W-1:0] w_op_code;
  pend_op_t          w_pend_nxt;
  logic              w_pend_clr;
  logic              w_stb_clr;
  logic [WIDTH-1:0]  w_acc;
  logic              w_ovf;

  assign w_cls       = classify(char_data);
  assign w_code      = token_code(char_data);
  // Held low during reset so no character is taken before the lexer is live
  assign char_ack    = RST && (r_state == S_IDLE || r_state == S_NUM);
  assign w_char_xfer = char_stb && char_ack;
  assign w_tok_xfer  = r_out_stb && output_ack;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_char_xfer) begin
          if (w_cls == CC_DIGIT) begin
            w_state_nxt = S_NUM;
          end else if (w_cls == CC_OP || w_cls == CC_TERM) begin
            w_state_nxt = S_EMIT_OP;
          end
        end
      end
      S_NUM: begin
        if (w_char_xfer && w_cls != CC_DIGIT) begin
          w_state_nxt = S_EMIT_NUM;
        end
      end
      S_EMIT_NUM: begin
        if (w_tok_xfer) begin
          w_state_nxt = r_pend.vld ? S_EMIT_OP : S_IDLE;
        end
      end
      S_EMIT_OP: begin
        if (w_tok_xfer) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath controls; token registers are loaded on entry to an emit state
  always_comb begin
    w_acc_clear = 1'b0;
    w_acc_load  = 1'b0;
    w_acc_mac   = 1'b0;
    w_num_load  = 1'b0;
    w_op_load   = 1'b0;
    w_op_code   = '0;
    w_pend_nxt  = '0;
    w_pend_clr  = 1'b0;
    w_stb_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_char_xfer) begin
          if (w_cls == CC_DIGIT) begin
            w_acc_load = 1'b1;
          end else if (w_cls == CC_OP || w_cls == CC_TERM) begin
            w_op_load = 1'b1;
            w_op_code = w_code;
          end
        end
      end
      S_NUM: begin
        if (w_char_xfer) begin
          if (w_cls == CC_DIGIT) begin
            w_acc_mac = 1'b1;
          end else begin
            w_num_load      = 1'b1;
            w_pend_nxt.vld  = (w_cls == CC_OP || w_cls == CC_TERM);
            w_pend_nxt.code = w_code;
          end
        end
      end
      S_EMIT_NUM: begin
        if (w_tok_xfer) begin
          w_pend_clr = 1'b1;
          if (r_pend.vld) begin
            w_op_load = 1'b1;
            w_op_code = r_pend.code;
          end else begin
            w_stb_clr   = 1'b1;
            w_acc_clear = 1'b1;
          end
        end
      end
      S_EMIT_OP: begin
        if (w_tok_xfer) begin
          w_stb_clr   = 1'b1;
          w_acc_clear = 1'b1;
        end
      end
      default: begin
        w_stb_clr = 1'b1;
      end
    endcase
  end

  dec_accum #(
    .WIDTH (WIDTH)
  ) u_dec_accum (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_clear    (w_acc_clear),
    .i_load     (w_acc_load),
    .i_mac      (w_acc_mac),
    .i_digit    (char_data[DIGIT_W-1:0]),
    .o_acc      (w_acc),
    .o_overflow (w_ovf)
  );

  // Token, pending operator and sticky bad-char registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_stb  <= 1'b0;
      r_out_data <= '0;
      r_out_op   <= 1'b0;
      r_pend     <= '0;
      r_bad      <= 1'b0;
    end else begin
      if (w_num_load) begin
        r_out_stb  <= 1'b1;
        r_out_data <= w_acc;
        r_out_op   <= TOK_OPERAND;
      end else if (w_op_load) begin
        r_out_stb  <= 1'b1;
        r_out_data <= WIDTH'(w_op_code);
        r_out_op   <= TOK_OPERATOR;
      end else if (w_stb_clr) begin
        r_out_stb  <= 1'b0;
      end

      if (w_num_load) begin
        r_pend <= w_pend_nxt;
      end else if (w_pend_clr) begin
        r_pend.vld <= 1'b0;
      end

      if (w_char_xfer && w_cls == CC_BAD) begin
        r_bad <= 1'b1;
      end
    end
  end

  assign output_stb         = r_out_stb;
  assign output_data        = r_out_data;
  assign is_output_operator = r_out_op;
  assign overflow           = w_ovf;
  assign bad_char           = r_bad;

endmodule

// File: tb/tb_token_lexer.sv
// Bench for token_lexer: a string-level reference lexer predicts the token
// queue and sticky flags; a negedge monitor checks every token transfer.
module tb_token_lexer;

  localparam int unsigned WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             char_stb = 1'b0;
  logic [7:0]       char_data = 8'h00;
  logic             char_ack;
  logic             output_stb;
  logic [WIDTH-1:0] output_data;
  logic             is_output_operator;
  logic             output_ack = 1'b0;
  logic             overflow;
  logic             bad_char;

  int vectors = 0;
  int miscompares = 0;
  int ack_mode = 0;

  logic [32:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic        m_bad = 1'b0;

  token_lexer #(.WIDTH(WIDTH)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .char_stb           (char_stb),
    .char_data          (char_data),
    .char_ack           (char_ack),
    .output_stb         (output_stb),
    .output_data        (output_data),
    .is_output_operator (is_output_operator),
    .output_ack         (output_ack),
    .overflow           (overflow),
    .bad_char           (bad_char)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lexer over a whole line; numbers tracked as unbounded-ish integers
  function automatic void model_line(input string s);
    longint unsigned acc = 0;
    bit in_num = 0;
    byte c;
    bit is_op, is_term;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") begin
        acc = in_num ? acc * 10 + longint'(c - 8'h30) : longint'(c - 8'h30);
        if (acc >= 64'h1_0000_0000) m_ovf = 1'b1;
        acc = acc % 64'h1_0000_0000;
        in_num = 1;
      end else begin
        is_op   = (c == "+" || c == "-" || c == "*" || c == "/" || c == "(" || c == ")");
        is_term = (c == "=" || c == 8'h0A);
        if (!is_op && !is_term && c != " ") m_bad = 1'b1;
        if (in_num) exp_q.push_back({1'b0, acc[31:0]});
        in_num = 0;
        if (is_op) exp_q.push_back({1'b1, 24'h0, c});
        if (is_term) exp_q.push_back({1'b1, 32'h3D});
      end
    end
  endfunction

  // Check the reference lexer itself against hand-written token lists
  task automatic pin_model(input string s, input logic [32:0] lit[$]);
    model_line(s);
    chk("pin_len", 64'(exp_q.size()), 64'(lit.size()));
    for (int i = 0; i < lit.size() && i < exp_q.size(); i++) chk("pin_tok", 64'(exp_q[i]), 64'(lit[i]));
    exp_q.delete();
  endtask

  always @(posedge CLK) begin
    #1;
    case (ack_mode)
      0:       output_ack = 1'b1;
      1:       output_ack = 1'($urandom_range(0, 1));
      default: output_ack = 1'b0;
    endcase
  end

  logic        prev_hold = 1'b0;
  logic [32:0] prev_tok = '0;
  logic [32:0] exp_tok;

  always @(negedge CLK) begin
    if (RST) begin
      if (prev_hold) begin
        chk("hold_stb", 64'(output_stb), 64'd1);
        chk("hold_tok", 64'({is_output_operator, output_data}), 64'(prev_tok));
      end
      if (output_stb) chk("char_ack_while_stb", 64'(char_ack), 64'd0);
      if (output_stb && output_ack) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_token: got %h with no token expected", {is_output_operator, output_data});
        end else begin
          exp_tok = exp_q.pop_front();
          chk("token", 64'({is_output_operator, output_data}), 64'(exp_tok));
        end
      end
      prev_hold = output_stb && !output_ack;
      prev_tok  = {is_output_operator, output_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the character was accepted
  task automatic send_char(input byte c);
    int n = 0;
    char_stb  = 1'b1;
    char_data = c;
    while (!char_ack && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!char_ack) begin
      vectors++;
      miscompares++;
      $display("FAIL char_timeout: char_ack stayed 0 for char %h", c);
    end
    @(posedge CLK); #1;
  endtask

  task automatic run_line(input string s);
    int n = 0;
    model_line(s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    char_stb = 1'b0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d tokens missing expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge CLK); #1;
    chk("idle_stb", 64'(output_stb), 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("bad_char", 64'(bad_char), 64'(m_bad));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  string       alph;
  string       s;
  logic [32:0] lit[$];

  initial begin
    alph = "0123456789 +-*/()#x\n";
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_stb", 64'(output_stb), 64'd0);
    chk("rst_data", 64'(output_data), 64'd0);
    chk("rst_isop", 64'(is_output_operator), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_bad", 64'(bad_char), 64'd0);
    chk("rst_char_ack", 64'(char_ack), 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    lit = '{33'h0_0000000C, 33'h1_0000002B, 33'h0_00000003, 33'h1_0000003D};
    pin_model("12+3=", lit);
    run_line("12+3=");
    chk("lit_ovf0", 64'(overflow), 64'd0);
    chk("lit_bad0", 64'(bad_char), 64'd0);

    lit = '{33'h1_00000028, 33'h0_00000004, 33'h1_0000002A, 33'h0_00000005,
            33'h1_00000029, 33'h1_0000003D};
    pin_model("( 4 *5)\n", lit);
    run_line("( 4 *5)\n");

    lit = '{33'h1_0000002D, 33'h0_00000007, 33'h1_0000003D};
    pin_model("-007=", lit);
    run_line("-007=");

    lit = '{33'h1_0000003D};
    pin_model("=", lit);
    run_line("=");

    lit = '{33'h0_00000000, 33'h1_0000003D};
    pin_model("4294967296=", lit);
    run_line("4294967296=");
    chk("lit_ovf1", 64'(overflow), 64'd1);

    lit = '{33'h0_00000009, 33'h0_00000001, 33'h1_0000003D};
    pin_model("9#1=", lit);
    run_line("9#1=");
    chk("lit_bad1", 64'(bad_char), 64'd1);
    chk("lit_ovf_sticky", 64'(overflow), 64'd1);

    // Downstream stall: number token must be held while ack is withheld
    ack_mode = 2;
    fork
      run_line("7+8=");
      begin
        int n = 0;
        while (!output_stb && n < 100) begin
          @(posedge CLK); #1;
          n++;
        end
        repeat (20) @(posedge CLK);
        #1;
        chk("stall_data", 64'(output_data), 64'd7);
        chk("stall_isop", 64'(is_output_operator), 64'd0);
        chk("stall_char_ack", 64'(char_ack), 64'd0);
        ack_mode = 0;
      end
    join

    ack_mode = 1;
    for (int l = 0; l < 30; l++) begin
      s = "";
      for (int k = $urandom_range(0, 12); k > 0; k--) begin
        int j;
        if ($urandom_range(0, 5) == 0) begin
          for (int d = $urandom_range(8, 12); d > 0; d--) begin
            j = $urandom_range(0, 9);
            s = {s, alph.substr(j, j)};
          end
        end else begin
          j = $urandom_range(0, alph.len() - 1);
          s = {s, alph.substr(j, j)};
        end
      end
      s = {s, "="};
      run_line(s);
    end

    // Asynchronous reset in the middle of a number discards it
    ack_mode = 0;
    send_char("5");
    send_char("6");
    char_stb = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk("async_stb", 64'(output_stb), 64'd0);
    chk("async_data", 64'(output_data), 64'd0);
    chk("async_isop", 64'(is_output_operator), 64'd0);
    chk("async_ovf", 64'(overflow), 64'd0);
    chk("async_bad", 64'(bad_char), 64'd0);
    chk("async_char_ack", 64'(char_ack), 64'd0);
    exp_q.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    lit = '{33'h0_00000002, 33'h1_0000003D};
    pin_model("2=", lit);
    run_line("2=");
    repeat (5) @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
